// File: rtl/alu32_seq_pkg.sv
// Shared opcode constants and FSM state type for the sequenced 32-bit ALU wrapper.
package alu32_seq_pkg;
   localparam logic [2:0] OP_XOR   = 3'd0;
   localparam logic [2:0] OP_ADD   = 3'd1;
   localparam logic [2:0] OP_AND   = 3'd2;
   localparam logic [2:0] OP_OR    = 3'd3;
   localparam logic [2:0] OP_NOT   = 3'd4;
   localparam logic [2:0] OP_ADD64 = 3'd5;

   typedef enum logic [1:0] {IDLE, EXEC_LO, EXEC_HI, RESP} state_t;

   function automatic logic op_legal(input logic [2:0] op);
      return op <= OP_ADD64;
   endfunction
endpackage

// File: rtl/alu32_seq_if.sv
// Request/response handshake bundle between a requester and alu32_seq.
interface alu32_seq_if;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [63:0] req_a;
   logic [63:0] req_b;
   logic        req_ci;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [63:0] rsp_data;
   logic        rsp_co;
   logic        rsp_err;

   modport master (
      output req_valid, req_op, req_a, req_b, req_ci, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_co, rsp_err
   );
   modport slave (
      input  req_valid, req_op, req_a, req_b, req_ci, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_co, rsp_err
   );
endinterface

// File: rtl/alu32_seq.sv
// Sequences one operation at a time through an external combinational 32-bit ALU;
// ADD64 takes two passes with the low-half carry chained into the high half.
module alu32_seq
   import alu32_seq_pkg::*;
#(
   parameter int ALU_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   alu32_seq_if.slave  bus,
   output logic [31:0] alu_in1,
   output logic [31:0] alu_in2,
   output logic        alu_ci,
   output logic [2:0]  alu_a,
   input  logic [31:0] alu_cout,
   input  logic        alu_co
);
   state_t      state;
   logic [2:0]  op_q;
   logic [31:0] a_hi;
   logic [31:0] b_hi;
   logic [3:0]  cnt;
   logic        last;

   assign last = (cnt == 4'(ALU_LAT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         op_q          <= '0;
         a_hi          <= '0;
         b_hi          <= '0;
         cnt           <= '0;
         bus.req_ready <= 1'b1;
         bus.rsp_valid <= 1'b0;
         bus.rsp_data  <= '0;
         bus.rsp_co    <= 1'b0;
         bus.rsp_err   <= 1'b0;
         alu_in1       <= '0;
         alu_in2       <= '0;
         alu_ci        <= 1'b0;
         alu_a         <= '0;
      end else begin
         case (state)
            IDLE: begin
               // req_ready is high exactly in IDLE, so req_valid alone means accept
               if (bus.req_valid) begin
                  op_q          <= bus.req_op;
                  a_hi          <= bus.req_a[63:32];
                  b_hi          <= bus.req_b[63:32];
                  cnt           <= '0;
                  bus.req_ready <= 1'b0;
                  if (op_legal(bus.req_op)) begin
                     state       <= EXEC_LO;
                     alu_a       <= (bus.req_op == OP_ADD64) ? OP_ADD : bus.req_op;
                     alu_in1     <= bus.req_a[31:0];
                     alu_in2     <= bus.req_b[31:0];
                     alu_ci      <= bus.req_ci;
                     bus.rsp_err <= 1'b0;
                  end else begin
                     state         <= RESP;
                     bus.rsp_valid <= 1'b1;
                     bus.rsp_data  <= '0;
                     bus.rsp_co    <= 1'b0;
                     bus.rsp_err   <= 1'b1;
                  end
               end
            end
            EXEC_LO: begin
               if (last) begin
                  cnt                 <= '0;
                  bus.rsp_data[31:0]  <= alu_cout;
                  if (op_q == OP_ADD64) begin
                     // low-half carry becomes the high pass carry-in
                     state   <= EXEC_HI;
                     alu_a   <= OP_ADD;
                     alu_in1 <= a_hi;
                     alu_in2 <= b_hi;
                     alu_ci  <= alu_co;
                  end else begin
                     state               <= RESP;
                     bus.rsp_valid       <= 1'b1;
                     bus.rsp_data[63:32] <= '0;
                     bus.rsp_co          <= (op_q == OP_ADD) && alu_co;
                     alu_a               <= '0;
                     alu_in1             <= '0;
                     alu_in2             <= '0;
                     alu_ci              <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            EXEC_HI: begin
               if (last) begin
                  cnt                 <= '0;
                  state               <= RESP;
                  bus.rsp_valid       <= 1'b1;
                  bus.rsp_data[63:32] <= alu_cout;
                  bus.rsp_co          <= alu_co;
                  alu_a               <= '0;
                  alu_in1             <= '0;
                  alu_in2             <= '0;
                  alu_ci              <= 1'b0;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  state         <= IDLE;
                  bus.rsp_valid <= 1'b0;
                  bus.req_ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
